// File: rtl/reg_file_if.sv
// Register-file access bundle: two combinational read ports, one write port and
// the ready flag that gates both once the post-reset clear sweep has finished.
interface reg_file_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  // Handshake: no per-transfer valid/ready pair. The master may present a read
  // address or a write (we3) on any cycle, but only cycles with ready=1 are
  // honoured: writes commit on that posedge and reads return register data.
  // With ready=0 writes are dropped and reads return 0.
  logic [AW-1:0]   a1;
  logic [AW-1:0]   a2;
  logic [AW-1:0]   a3;
  logic            we3;
  logic [XLEN-1:0] wd3;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            ready;

  modport master (
    output a1, a2, a3, we3, wd3,
    input  rd1, rd2, ready
  );

  modport slave (
    input  a1, a2, a3, we3, wd3,
    output rd1, rd2, ready
  );
endinterface

// File: rtl/reg_file.sv
// Integer register file x0..x(NREGS-1): two combinational read ports, one
// synchronous write port, and a post-reset sweep that zeroes x1..x(NREGS-1).
module reg_file #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_if.slave    bus,
  output logic         dbgState
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } stateT;

  stateT           state;
  stateT           stateNext;
  logic [AW-1:0]   clrIdx;
  logic [AW-1:0]   clrIdxNext;
  logic [XLEN-1:0] regs [NREGS];
  logic            wrActive;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLEAR;
      clrIdx <= AW'(1);
    end else begin
      state  <= stateNext;
      clrIdx <= clrIdxNext;
    end
  end

  always_comb begin
    stateNext  = state;
    clrIdxNext = clrIdx;
    if (state == CLEAR) begin
      clrIdxNext = clrIdx + 1'b1;
      if (clrIdx == LAST_IDX) begin
        stateNext = READY;
      end
    end
  end

  assign wrActive = (state == READY) && bus.we3 && (bus.a3 != '0);

  // Contents have no reset: the sweep owns the write port until READY, and
  // entry 0 is never written because x0 is decoded as constant zero on read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clrIdx] <= '0;
      end else if (wrActive) begin
        regs[bus.a3] <= bus.wd3;
      end
    end
  end

  always_comb begin
    bus.rd1 = '0;
    if ((state == READY) && (bus.a1 != '0)) begin
      if ((BYPASS != 0) && wrActive && (bus.a3 == bus.a1)) begin
        bus.rd1 = bus.wd3;
      end else begin
        bus.rd1 = regs[bus.a1];
      end
    end
  end

  always_comb begin
    bus.rd2 = '0;
    if ((state == READY) && (bus.a2 != '0)) begin
      if ((BYPASS != 0) && wrActive && (bus.a3 == bus.a2)) begin
        bus.rd2 = bus.wd3;
      end else begin
        bus.rd2 = regs[bus.a2];
      end
    end
  end

  assign bus.ready = (state == READY);
  assign dbgState  = state;
endmodule

// File: tb/tb_reg_file.sv
// Directed scenarios plus randomized traffic for reg_file, checked against a
// behavioural model of register contents and sweep progress.
module tb_reg_file;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int BYPASS = 1;

  logic clk;
  logic rst;
  logic dbgState;

  reg_file_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  reg_file #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [XLEN-1:0] mem [NREGS];
  bit              mReady;
  int              sweepEdges;
  logic [XLEN-1:0] exp_q [$];

  int total;
  int bad;

  function automatic logic [XLEN-1:0] expRead(input int a);
    if (!mReady || a == 0) return '0;
    if (BYPASS != 0 && bus.we3 && int'(bus.a3) == a) return bus.wd3;
    return mem[a];
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic setBus(input logic we, input logic [4:0] wa, input logic [XLEN-1:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2);
    bus.we3 = we;
    bus.a3  = wa;
    bus.wd3 = wd;
    bus.a1  = ra1;
    bus.a2  = ra2;
  endtask

  // Apply the effect of the coming posedge to the model, then step past it.
  task automatic clkEdge();
    if (rst) begin
      mReady     = 1'b0;
      sweepEdges = 0;
    end else if (!mReady) begin
      sweepEdges++;
      if (sweepEdges == NREGS - 1) begin
        mReady = 1'b1;
        for (int i = 0; i < NREGS; i++) mem[i] = '0;
      end
    end else if (bus.we3 && bus.a3 != 0) begin
      mem[bus.a3] = bus.wd3;
    end
    @(posedge clk);
    #1;
    chk("ready", XLEN'(bus.ready), XLEN'(mReady));
  endtask

  task automatic checkReads(input string tag);
    exp_q.push_back(expRead(int'(bus.a1)));
    exp_q.push_back(expRead(int'(bus.a2)));
    #1;
    chk({tag, "_rd1"}, bus.rd1, exp_q.pop_front());
    chk({tag, "_rd2"}, bus.rd2, exp_q.pop_front());
  endtask

  initial begin
    logic       we;
    logic [4:0] wa;
    logic [4:0] ra1;
    logic [4:0] ra2;
    total      = 0;
    bad        = 0;
    mReady     = 1'b0;
    sweepEdges = 0;
    rst        = 1'b1;
    setBus(1'b0, 5'd0, '0, 5'd5, 5'd0);

    // 1: reset sweep
    clkEdge();
    clkEdge();
    chk("reset_rd1", bus.rd1, '0);
    rst = 1'b0;
    for (int i = 1; i <= NREGS - 1; i++) begin
      clkEdge();
      chk("sweep_ready", XLEN'(bus.ready), XLEN'(i == NREGS - 1));
      chk("sweep_rd1", bus.rd1, '0);
    end

    // 2: write then read two registers
    setBus(1'b1, 5'd5, 32'h00000001, 5'd5, 5'd6);
    clkEdge();
    setBus(1'b1, 5'd6, 32'h00000010, 5'd5, 5'd6);
    clkEdge();
    setBus(1'b0, 5'd0, '0, 5'd5, 5'd6);
    #1;
    chk("wr_rd1", bus.rd1, 32'h00000001);
    chk("wr_rd2", bus.rd2, 32'h00000010);
    chk("alu_sum", bus.rd1 + bus.rd2, 32'h00000011);

    // 3: x0 ignores writes
    setBus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    chk("x0_before", bus.rd1, '0);
    clkEdge();
    chk("x0_after", bus.rd1, '0);

    // 4: write-to-read bypass
    setBus(1'b1, 5'd7, 32'hAAAA0000, 5'd0, 5'd0);
    clkEdge();
    setBus(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0);
    #1;
    chk("bypass_before", bus.rd1, (BYPASS != 0) ? 32'h12345678 : 32'hAAAA0000);
    clkEdge();
    setBus(1'b0, 5'd0, '0, 5'd7, 5'd0);
    #1;
    chk("bypass_after", bus.rd1, 32'h12345678);

    // 5: reset pulse mid-sweep; writes during sweep are lost
    rst = 1'b1;
    clkEdge();
    rst = 1'b0;
    setBus(1'b1, 5'd3, 32'h33333333, 5'd3, 5'd0);
    repeat (9) clkEdge();
    rst = 1'b1;
    clkEdge();
    rst = 1'b0;
    for (int i = 1; i <= NREGS - 1; i++) begin
      clkEdge();
      chk("resweep_ready", XLEN'(bus.ready), XLEN'(i == NREGS - 1));
    end
    setBus(1'b0, 5'd0, '0, 5'd3, 5'd3);
    #1;
    chk("lost_x3", bus.rd1, '0);

    // 6: dual port on the same register
    setBus(1'b1, 5'd9, 32'hDEADBEEF, 5'd0, 5'd0);
    clkEdge();
    setBus(1'b0, 5'd0, '0, 5'd9, 5'd9);
    #1;
    chk("dual_rd1", bus.rd1, 32'hDEADBEEF);
    chk("dual_rd2", bus.rd2, 32'hDEADBEEF);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, NREGS - 1));
      ra1 = 5'($urandom_range(0, NREGS - 1));
      ra2 = 5'($urandom_range(0, NREGS - 1));
      if ($urandom_range(0, 3) == 0) ra1 = wa;
      if ($urandom_range(0, 5) == 0) ra2 = wa;
      setBus(we, wa, $urandom, ra1, ra2);
      checkReads("rand");
      clkEdge();
    end

    // reset after use: full sweep zeroes everything
    setBus(1'b0, 5'd0, '0, 5'd0, 5'd0);
    rst = 1'b1;
    clkEdge();
    rst = 1'b0;
    repeat (NREGS - 1) clkEdge();
    for (int a = 1; a < NREGS; a++) begin
      setBus(1'b0, 5'd0, '0, 5'(a), 5'(NREGS - a));
      #1;
      chk("final_rd1", bus.rd1, '0);
      chk("final_rd2", bus.rd2, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
